// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG byte reader.
//   MARKER_PREFIX .. RST7 : JPEG marker byte values
//   parse_state_e         : byte parser states
//   fifo_word_t           : output FIFO entry {is_marker, data}
package jpeg_pkg;

    localparam logic [7:0] MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] STUFF_BYTE    = 8'h00;
    localparam logic [7:0] SOI           = 8'hD8;
    localparam logic [7:0] EOI           = 8'hD9;
    localparam logic [7:0] RST0          = 8'hD0;
    localparam logic [7:0] RST7          = 8'hD7;

    typedef enum logic [1:0] {
        NORMAL,
        GOT_FF,
        STOP
    } parse_state_e;

    typedef struct packed {
        logic       is_marker;
        logic [7:0] data;
    } fifo_word_t;

endpackage

// File: rtl/jpeg_byte_reader_if.sv
// Output stream of the JPEG byte reader (valid/ready handshake).
//   out_data      : de-stuffed data byte or marker code
//   out_is_marker : out_data is a marker code
//   out_valid     : entry available
//   out_ready     : sink accepts; transfer on out_valid && out_ready
interface jpeg_byte_reader_if;

    logic [7:0] out_data;
    logic       out_is_marker;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_is_marker,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_is_marker,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/jpeg_byte_fifo.sv
// First-word-fall-through FIFO of parsed entries.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full and not popping)
//   pop      : drop head entry (ignored when empty)
//   rdata    : head entry, zero when empty
//   empty    : no entries
//   count    : current occupancy
module jpeg_byte_fifo
    import jpeg_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fifo_word_t             wdata,
    input  logic                   pop,
    output fifo_word_t             rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fifo_word_t      mem [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    assign rdata   = empty ? '0 : mem[rptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/jpeg_byte_reader.sv
// Reads a JPEG byte stream from a ROM, removes byte stuffing and fill bytes,
// and emits data bytes and marker codes through an output FIFO.
//   clk, rst      : clock, synchronous active-high reset
//   rom_rd_en     : ROM read strobe, one byte per strobe
//   rom_data      : ROM byte, valid the cycle after rom_rd_en
//   rom_done      : next strobe reads the last ROM byte
//   strm          : output stream (data / is_marker / valid / ready)
//   soi_seen      : sticky, SOI marker parsed
//   done          : stream finished and fully drained
//   err           : sticky, ROM ended while a 0xFF was pending
module jpeg_byte_reader
    import jpeg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_rd_en,
    input  logic [7:0]                 rom_data,
    input  logic                       rom_done,
    jpeg_byte_reader_if.master         strm,
    output logic                       soi_seen,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

    parse_state_e    state_q, state_d;
    logic            inflight_q, exhausted_q, soi_q, err_q;
    logic            push, pop, set_soi, set_err, fifo_empty;
    fifo_word_t      push_word, head;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   occupancy;

    // A read is a credit on a FIFO slot until its byte is parsed.
    assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    assign rom_rd_en = !rst && (state_q != STOP) && !exhausted_q && (occupancy < DepthLim);

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_word = '0;
        set_soi   = 1'b0;
        set_err   = 1'b0;
        if (inflight_q) begin
            unique case (state_q)
                NORMAL: begin
                    if (rom_data == MARKER_PREFIX) begin
                        state_d = GOT_FF;
                    end else begin
                        push      = 1'b1;
                        push_word = '{is_marker: 1'b0, data: rom_data};
                    end
                end
                GOT_FF: begin
                    if (rom_data == STUFF_BYTE) begin
                        push      = 1'b1;
                        push_word = '{is_marker: 1'b0, data: MARKER_PREFIX};
                        state_d   = NORMAL;
                    end else if (rom_data != MARKER_PREFIX) begin
                        // Repeated 0xFF is fill and leaves us in GOT_FF.
                        push      = 1'b1;
                        push_word = '{is_marker: 1'b1, data: rom_data};
                        set_soi   = (rom_data == SOI);
                        state_d   = (rom_data == EOI) ? STOP : NORMAL;
                    end
                end
                STOP: ;  // late byte from a read already in flight
                default: state_d = NORMAL;
            endcase
            // exhausted_q set while capturing means this is the final byte.
            if (exhausted_q && state_d == GOT_FF) begin
                set_err = 1'b1;
                state_d = STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NORMAL;
            inflight_q  <= 1'b0;
            exhausted_q <= 1'b0;
            soi_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rom_rd_en;
            if (rom_rd_en && rom_done) exhausted_q <= 1'b1;
            if (set_soi) soi_q <= 1'b1;
            if (set_err) err_q <= 1'b1;
        end
    end

    assign pop = strm.out_valid && strm.out_ready;

    jpeg_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign strm.out_valid     = !fifo_empty;
    assign strm.out_data      = head.data;
    assign strm.out_is_marker = head.is_marker;

    assign soi_seen = soi_q;
    assign err      = err_q;
    assign done     = ((state_q == STOP) || exhausted_q) && !inflight_q && fifo_empty;

endmodule

// File: doc/jpeg_byte_reader.md
JPEG_BYTE_READER -- requirements
Module: jpeg_byte_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rom_rd_en  output  1  read strobe to byte ROM; one byte per strobe.
REQ-005 SHALL have port rom_data  input  8  ROM byte, valid the cycle after rom_rd_en.
REQ-006 SHALL have port rom_done  input  1  high when the next strobe reads the last ROM byte.
REQ-007 SHALL have port out_data  output  8  de-stuffed data byte or marker code.
REQ-008 SHALL have port out_is_marker  output  1  out_data is a marker code (byte after 0xFF).
REQ-009 SHALL have port out_valid  output  1  output entry available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid&&out_ready.
REQ-011 SHALL have port soi_seen  output  1  sticky; marker 0xD8 parsed.
REQ-012 SHALL have port done  output  1  stream finished and fully drained.
REQ-013 SHALL have port err  output  1  sticky; ROM exhausted while a 0xFF was pending.

Function
REQ-014 SHALL assert rom_rd_en only when FIFO occupancy + in-flight reads < FIFO_DEPTH and state is not STOP.
REQ-015 SHALL capture rom_data exactly one cycle after each rom_rd_en; at most one read in flight.
REQ-016 SHALL set internal flag exhausted when rom_rd_en issues while rom_done=1; no further strobes after that.
REQ-017 SHALL run parser FSM states NORMAL, GOT_FF, STOP on each captured byte.
REQ-018 NORMAL: byte!=0xFF -> push {0,byte}; byte==0xFF -> GOT_FF, push nothing.
REQ-019 GOT_FF: 0x00 -> push {0,0xFF}, NORMAL; 0xFF -> stay GOT_FF (fill byte, discarded); other -> push {1,byte}, NORMAL.
REQ-020 Marker 0xD8 SHALL set soi_seen; marker 0xD9 SHALL be pushed then enter STOP.
REQ-021 STOP: rom_rd_en held low; any byte returned by a read already in flight SHALL be discarded.
REQ-022 Markers 0xD0-0xD7 and all others SHALL pass through as marker entries without special action.
REQ-023 Parser SHALL push at most one entry per captured byte; credit check guarantees push never meets a full FIFO.
REQ-024 Last byte of exhausted ROM captured in GOT_FF SHALL set err and enter STOP.
REQ-025 done SHALL be 1 when (STOP or exhausted and last byte parsed) and FIFO empty and no read in flight.
REQ-026 FIFO SHALL support simultaneous push and pop when full-minus-zero/empty per standard FIFO rules; pop of empty ignored.
REQ-027 out_data/out_is_marker SHALL present FIFO head, first-word-fall-through; stable while out_valid&&!out_ready.

Reset
REQ-028 rst SHALL clear: rom_rd_en=0, out_valid=0, out_data=0, out_is_marker=0, soi_seen=0, done=0, err=0, FSM=NORMAL, FIFO empty, in-flight and exhausted cleared.
REQ-029 rst mid-stream SHALL abort immediately; any byte returned in the cycle after reset is discarded.
REQ-030 First rom_rd_en SHALL occur no earlier than the first cycle after rst deasserts.

Structure
REQ-031 Package jpeg_pkg SHALL hold constants MARKER_PREFIX 0xFF, STUFF_BYTE 0x00, SOI 0xD8, EOI 0xD9, RST0 0xD0, RST7 0xD7, and the parser state enum.
REQ-032 FIFO SHALL be sub-module jpeg_byte_fifo, 9-bit wide {is_marker,data}, depth FIFO_DEPTH.
REQ-033 Credit/read control and parser FSM SHALL live in jpeg_byte_reader top.

Verification
REQ-034 Stream FF D8 12 FF 00 34 FF D9, out_ready=1 -> outputs {1,D8},{0,12},{0,FF},{0,34},{1,D9}; soi_seen=1; done=1; err=0.
REQ-035 Stream FF FF FF D0 56 -> fills dropped; outputs {1,D0},{0,56}.
REQ-036 out_ready=0 for 20 cycles, FIFO_DEPTH=4 -> exactly 4 entries buffered, rom_rd_en low, no loss; release -> full sequence in order.
REQ-037 EOI followed by AA BB in ROM -> AA,BB never output; rom_rd_en low after EOI parsed; done after drain.
REQ-038 ROM ending ... 77 FF (rom_done at last read) -> 77 output, err=1, done=1 after drain.
REQ-039 rst asserted mid-stream with FIFO holding 3 entries -> next cycle out_valid=0, flags 0; post-reset parse restarts cleanly.
